piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter. It drives the single-bit serial data line that the team's D flip-flop capture stage samples on the far end. A word is accepted through a valid/ready handshake, then shifted out one bit per clock with a frame-start marker and bit-valid qualifier. Back-to-back words are supported with no idle gap.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_shift_reg.sv | 57 +++++
 rtl/piso_serializer.sv | 120 ++++++++++++
 tb/tb_piso_serializer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in, serial-out transmitter.
//   DefaultWidth : default number of bits per word
//   state_e      : transmitter FSM state encoding (idle = 0, shifting = 1)
package piso_serializer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register with selectable shift direction.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset, clears the register
//   load_i   : capture data_i (its first bit leaves straight through serial_o)
//   shift_i  : advance the stored word by one bit
//   data_i   : parallel word to load
//   serial_o : bit to drive next: first bit of data_i while loading, else head of register
module piso_shift_reg #(
  parameter int unsigned Width    = 8,
  parameter bit          MsbFirst = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             serial_o
);

  logic [Width-1:0] sreg_q, sreg_d;
  logic [Width-1:0] load_val, shift_val;
  logic             data_head, reg_head;

  // The first bit is consumed on the load edge, so the register stores the word
  // already advanced by one position; its head is always the next bit to send.
  if (MsbFirst) begin : g_msb
    assign data_head = data_i[Width-1];
    assign load_val  = {data_i[Width-2:0], 1'b0};
    assign reg_head  = sreg_q[Width-1];
    assign shift_val = {sreg_q[Width-2:0], 1'b0};
  end else begin : g_lsb
    assign data_head = data_i[0];
    assign load_val  = {1'b0, data_i[Width-1:1]};
    assign reg_head  = sreg_q[0];
    assign shift_val = {1'b0, sreg_q[Width-1:1]};
  end

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = load_val;
    end else if (shift_i) begin
      sreg_d = shift_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign serial_o = load_i ? data_head : reg_head;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready word intake.
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-low reset
//   data_in     : parallel word, sampled only on the accepting edge
//   data_valid  : data_in holds a word to send
//   data_ready  : a word can be accepted this cycle (combinational)
//   q           : registered serial data line, IDLE_LEVEL when not sending
//   q_valid     : q carries a data bit this cycle
//   frame_start : q carries the first bit of a word
//   busy        : a word is being shifted out (same as q_valid)
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             q,
  output logic             q_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_q, q_d;
  logic            q_valid_q, q_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            load, shift, serial_bit, accept;

  assign data_ready = rst && ((state_q == StIdle) || (cnt_q == LastCnt));
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    q_d           = IDLE_LEVEL;
    q_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load          = 1'b1;
          cnt_d         = '0;
          q_d           = serial_bit;
          q_valid_d     = 1'b1;
          frame_start_d = 1'b1;
          state_d       = StShift;
        end
      end
      StShift: begin
        if (cnt_q != LastCnt) begin
          shift     = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          q_d       = serial_bit;
          q_valid_d = 1'b1;
        end else if (accept) begin
          // Reload on the last-bit edge so the next word follows with no gap.
          load          = 1'b1;
          cnt_d         = '0;
          q_d           = serial_bit;
          q_valid_d     = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      q_q           <= IDLE_LEVEL;
      q_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      q_q           <= q_d;
      q_valid_q     <= q_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  piso_shift_reg #(
    .Width    (WIDTH),
    .MsbFirst (MSB_FIRST)
  ) u_shift_reg (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (load),
    .shift_i  (shift),
    .data_i   (data_in),
    .serial_o (serial_bit)
  );

  assign q           = q_q;
  assign q_valid     = q_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = q_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;

  logic l_ready, l_q, l_qv, l_fs, l_busy;
  logic m_ready, m_q, m_qv, m_fs, m_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .q(l_q), .q_valid(l_qv), .frame_start(l_fs), .busy(l_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_ready), .q(m_q), .q_valid(m_qv), .frame_start(m_fs), .busy(m_busy)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each word becomes a list of bits in send order; a new word is taken only
  // when no bits of the previous word remain to be sent after the current one.
  bit pend[2][$];
  bit mod_q[2], mod_qv[2], mod_fs[2];
  bit chk_en = 1'b0;

  function automatic bit model_ready(input int d);
    return rst && (pend[d].size() == 0);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        pend[d].delete();
        mod_q[d] = 1'b0; mod_qv[d] = 1'b0; mod_fs[d] = 1'b0;
      end else if (data_valid && model_ready(d)) begin
        for (int i = 1; i < W; i++) pend[d].push_back((d == 1) ? data_in[W-1-i] : data_in[i]);
        mod_q[d]  = (d == 1) ? data_in[W-1] : data_in[0];
        mod_qv[d] = 1'b1;
        mod_fs[d] = 1'b1;
      end else if (pend[d].size() > 0) begin
        mod_q[d]  = pend[d].pop_front();
        mod_qv[d] = 1'b1;
        mod_fs[d] = 1'b0;
      end else begin
        mod_q[d] = 1'b0; mod_qv[d] = 1'b0; mod_fs[d] = 1'b0;
      end
    end
    if (!rst) chk_en = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("lsb_q", l_q, mod_q[0]);
      check("lsb_q_valid", l_qv, mod_qv[0]);
      check("lsb_frame_start", l_fs, mod_fs[0]);
      check("lsb_busy", l_busy, mod_qv[0]);
      check("lsb_data_ready", l_ready, model_ready(0));
      check("msb_q", m_q, mod_q[1]);
      check("msb_q_valid", m_qv, mod_qv[1]);
      check("msb_frame_start", m_fs, mod_fs[1]);
      check("msb_busy", m_busy, mod_qv[1]);
      check("msb_data_ready", m_ready, model_ready(1));
    end
  end

  // Sends one word, scrambling data_in while it is shifted out. Sequences are
  // packed so that reading left to right follows time order.
  task automatic send_word(input logic [W-1:0] w, output logic [W-1:0] ls, output logic [W-1:0] ms,
                           output logic [W-1:0] mls, output logic [W-1:0] mms);
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(posedge clk);
      #1;
      ls[W-1-i]  = l_q;
      ms[W-1-i]  = m_q;
      mls[W-1-i] = mod_q[0];
      mms[W-1-i] = mod_q[1];
      @(negedge clk);
      data_valid = 1'b0;
      data_in    = W'($urandom);
    end
    repeat (3) @(negedge clk);
  endtask

  logic [W-1:0] ls, ms, mls, mms;
  logic [19:0]  qv_seq, fs_seq;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_q", l_q, 1'b0);
      check("idle_q_valid", l_qv, 1'b0);
      check("idle_ready", l_ready, 1'b1);
    end

    send_word(8'hA5, ls, ms, mls, mms);
    check_vec("a5_lsb_seq", 32'(ls), 32'h0000_00A5);
    check_vec("a5_msb_seq", 32'(ms), 32'h0000_00A5);
    check_vec("a5_model_lsb_seq", 32'(mls), 32'h0000_00A5);

    // Back-to-back words with data_valid held high.
    @(negedge clk);
    data_in    = 8'h3C;
    data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      qv_seq[i] = l_qv;
      fs_seq[i] = l_fs;
      @(negedge clk);
      if (i == 0) data_in = 8'hC3;
      if (i == 8) data_valid = 1'b0;
    end
    check_vec("b2b_q_valid_run", 32'(qv_seq), 32'h0000_FFFF);
    check_vec("b2b_frame_starts", 32'(fs_seq), 32'h0000_0101);

    send_word(8'h81, ls, ms, mls, mms);
    check_vec("81_msb_seq", 32'(ms), 32'h0000_0081);
    check_vec("81_model_msb_seq", 32'(mms), 32'h0000_0081);
    send_word(8'h80, ls, ms, mls, mms);
    check_vec("80_msb_seq", 32'(ms), 32'h0000_0080);
    check_vec("80_lsb_seq", 32'(ls), 32'h0000_0001);
    check_vec("80_model_msb_seq", 32'(mms), 32'h0000_0080);

    // Reset in the middle of 8'hFF, after bit 3 has been on the line.
    @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ff_bit3_q", l_q, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_q", l_q, 1'b0);
    check("midrst_q_valid", l_qv, 1'b0);
    check("midrst_busy", l_busy, 1'b0);
    check("midrst_ready_low", l_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", l_ready, 1'b1);

    send_word(8'h01, ls, ms, mls, mms);
    check_vec("01_lsb_seq", 32'(ls), 32'h0000_0080);
    check_vec("01_msb_seq", 32'(ms), 32'h0000_0001);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
